// File: rtl/btn_pkg.sv
// Shared types and constants for the button conditioning front end.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } btn_state_t;

    localparam int DEF_DB_CYCLES  = 250000;    // 10 ms at 25 MHz
    localparam int DEF_RPT_DELAY  = 12500000;
    localparam int DEF_RPT_PERIOD = 5000000;

    localparam int BTN_MOVE   = 0;
    localparam int BTN_SELECT = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, saturating counter and debounce FSM.
// Auto-repeat while held is compiled in only with BTN_AUTOREPEAT_EN.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic vga_clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press,
    output logic rel
);

`ifdef BTN_AUTOREPEAT_EN
    localparam int CNT_MAX = max3(DB_CYCLES, RPT_DELAY, RPT_PERIOD);
`else
    localparam int CNT_MAX = DB_CYCLES;
`endif
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    if (DB_CYCLES < 2 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_param
        $error("btn_channel: DB_CYCLES must be >= 2 and RPT_* >= 1");
    end

    logic [1:0]    sync;
    logic          s;
    btn_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          press_evt, rel_evt;
    logic          press_q, rel_q;

    // Synchroniser resets to "released" so a held button is re-debounced.
    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) sync <= 2'b11;
        else      sync <= {sync[0], btn_n};
    end

    assign s       = ~sync[1];
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CW-1:0] RPT_D_LAST = CW'(RPT_DELAY - 1);
    localparam logic [CW-1:0] RPT_P_LAST = CW'(RPT_PERIOD - 1);
    logic rpt_on, rpt_nxt;

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) rpt_on <= 1'b0;
        else      rpt_on <= rpt_nxt;
    end
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_evt = 1'b0;
        rel_evt   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rpt_nxt   = rpt_on;
`endif
        case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    press_evt = 1'b1;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end
            HELD: begin
                if (!s) begin
                    state_nxt = REL_WAIT;
                    cnt_nxt   = CNT_ONE;
`ifdef BTN_AUTOREPEAT_EN
                    rpt_nxt   = 1'b0;   // a bounce back to HELD restarts the delay
`endif
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    if ((!rpt_on && cnt == RPT_D_LAST) || (rpt_on && cnt == RPT_P_LAST)) begin
                        press_evt = 1'b1;
                        cnt_nxt   = '0;
                        rpt_nxt   = 1'b1;
                    end else begin
                        cnt_nxt   = cnt_inc;
                    end
`else
                    cnt_nxt = cnt_inc;
`endif
                end
            end
            REL_WAIT: begin
                if (s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    rel_evt   = 1'b1;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Events are staged once more so pulses line up with the registered level.
    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            level   <= 1'b0;
            press   <= 1'b0;
            rel     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            press_q <= press_evt;
            rel_q   <= rel_evt;
            level   <= (state == HELD) || (state == REL_WAIT);
            press   <= press_q;
            rel     <= rel_q;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Synchronises and debounces N_BTN active-low buttons into clean level/press/release.
// Optional auto-repeat on held buttons: define BTN_AUTOREPEAT_EN.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN      = 2,
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic             vga_clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES  (DB_CYCLES),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD)
        ) u_ch (
            .vga_clk (vga_clk),
            .rst     (rst),
            .btn_n   (btn_n[i]),
            .level   (btn_level[i]),
            .press   (btn_press[i]),
            .rel     (btn_release[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed + random bench for btn_conditioner against a run-length debounce model.
module tb_btn_conditioner;

    localparam int N  = 2;
    localparam int DB = 4;

    logic         vga_clk = 1'b0;
    logic         rst     = 1'b0;
    logic [N-1:0] btn_n   = '1;
    logic [N-1:0] btn_level, btn_press, btn_release;

    int passed = 0;
    int total  = 0;

    always #5 vga_clk = ~vga_clk;

    btn_conditioner #(
        .N_BTN      (N),
        .DB_CYCLES  (DB),
        .RPT_DELAY  (10),
        .RPT_PERIOD (3)
    ) dut (
        .vga_clk     (vga_clk),
        .rst         (rst),
        .btn_n       (btn_n),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    // Model: the debounced level flips once the synchronised input has disagreed
    // with it for DB consecutive samples; outputs show that one cycle later.
    logic [N-1:0] h1, h2, m_lvl, np, nr;
    logic [N-1:0] exp_level, exp_press, exp_release;
    int           run [N];

    task automatic model_reset();
        h1 = '1; h2 = '1; m_lvl = '0; np = '0; nr = '0;
        exp_level = '0; exp_press = '0; exp_release = '0;
        for (int c = 0; c < N; c++) run[c] = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] raw);
        logic [N-1:0] s;
        s           = ~h2;
        h2          = h1;
        h1          = raw;
        exp_level   = m_lvl;
        exp_press   = np;
        exp_release = nr;
        np = '0;
        nr = '0;
        for (int c = 0; c < N; c++) begin
            if (s[c] != m_lvl[c]) begin
                run[c]++;
                if (run[c] == DB) begin
                    m_lvl[c] = s[c];
                    run[c]   = 0;
                    np[c]    = s[c];
                    nr[c]    = ~s[c];
                end
            end else begin
                run[c] = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(input logic [N-1:0] raw, input string tag);
        btn_n = raw;
        @(posedge vga_clk);
        model_edge(raw);
        #1;
        check({tag, ".level"},   btn_level,   exp_level);
        check({tag, ".press"},   btn_press,   exp_press);
        check({tag, ".release"}, btn_release, exp_release);
        @(negedge vga_clk);
    endtask

    initial begin
        logic [N-1:0] rnd_val;
        int           seg [N];

        model_reset();
        repeat (2) @(negedge vga_clk);
        check("reset.level",   btn_level,   '0);
        check("reset.press",   btn_press,   '0);
        check("reset.release", btn_release, '0);
        rst = 1'b1;

        repeat (20) cycle(2'b10, "clean_press");
        repeat (3)  cycle(2'b11, "rel_glitch");
        repeat (10) cycle(2'b10, "rel_glitch_back");
        repeat (12) cycle(2'b11, "release");

        for (int b = 0; b < 5; b++) begin
            repeat (2) cycle(2'b01, "bounce_low");
            cycle(2'b11, "bounce_high");
        end
        repeat (12) cycle(2'b01, "bounce_steady");
        repeat (12) cycle(2'b11, "bounce_release");

        // ch1 held, ch0 part-way through its press debounce, then reset
        repeat (10) cycle(2'b01, "pre_reset_hold1");
        repeat (4)  cycle(2'b00, "pre_reset_pw0");
        rst = 1'b0;
        #1;
        check("reset_mid.level",   btn_level,   '0);
        check("reset_mid.press",   btn_press,   '0);
        check("reset_mid.release", btn_release, '0);
        model_reset();
        repeat (2) @(negedge vga_clk);
        check("reset_hold.level", btn_level, '0);
        rst = 1'b1;
        repeat (12) cycle(2'b00, "post_reset");
        repeat (12) cycle(2'b11, "post_reset_rel");

        for (int c = 0; c < N; c++) seg[c] = 0;
        rnd_val = '1;
        for (int t = 0; t < 400; t++) begin
            for (int c = 0; c < N; c++) begin
                if (seg[c] == 0) begin
                    seg[c]     = $urandom_range(1, 8);
                    rnd_val[c] = 1'($urandom_range(0, 1));
                end
                seg[c]--;
            end
            cycle(rnd_val, "random");
        end
        repeat (12) cycle(2'b11, "final_release");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end conditioning stage for the memory-game board buttons (move, select). It synchronises the raw active-low push-button inputs into the `vga_clk` domain and debounces them. It then produces a clean level plus single-cycle press/release pulses per button, which feed directly into `controlesJuego`, `memory` and `FSMJuegoGeneral`. Those consumers no longer invert or edge-detect raw pins themselves.

## Interface
Parameters:
- `N_BTN`, default 2: number of button channels (bit 0 = move, bit 1 = select).
- `DB_CYCLES`, default 250000: stable cycles required to accept a change (10 ms at 25 MHz); legal range ≥ 2.
- `RPT_DELAY`, default 12500000: held cycles before the first auto-repeat pulse (only with `BTN_AUTOREPEAT_EN`).
- `RPT_PERIOD`, default 5000000: cycles between subsequent repeat pulses (only with `BTN_AUTOREPEAT_EN`).

Ports:
- `vga_clk` in, 1: single clock for the whole block (25 MHz).
- `rst` in, 1: asynchronous, active-low reset.
- `btn_n` in, N_BTN: raw board buttons, active-low, asynchronous to `vga_clk`.
- `btn_level` out, N_BTN: debounced state, 1 = pressed.
- `btn_press` out, N_BTN: one-cycle pulse on accepted press (and on repeats).
- `btn_release` out, N_BTN: one-cycle pulse on accepted release.

## Operation
- Channels are fully independent and identical.
- **Synchroniser:** 2 flops on `btn_n`, reset to 1 (released). `s` = inverted second-flop output.
- **Counter:** width `$clog2(max(DB_CYCLES, RPT_DELAY, RPT_PERIOD)+1)`, unsigned, saturates and never wraps.
- **FSM states:** `IDLE`, `PRESS_WAIT`, `HELD`, `REL_WAIT`.
  - `IDLE`: if s=1, go to `PRESS_WAIT`, cnt←1.
  - `PRESS_WAIT`: if s=0, go to `IDLE`, cnt←0. Else if cnt==DB_CYCLES-1, go to `HELD`, cnt←0, pulse `btn_press`. Else cnt+1.
  - `HELD`: if s=0, go to `REL_WAIT`, cnt←1. Else cnt increments (auto-repeat use only).
  - `REL_WAIT`: if s=1, go to `HELD`, cnt←0, no pulse. Else if cnt==DB_CYCLES-1, go to `IDLE`, cnt←0, pulse `btn_release`. Else cnt+1.
- `btn_level` = 1 in `HELD` and `REL_WAIT`, else 0. It is registered.
- Glitches shorter than DB_CYCLES never produce pulses or a level change.
- `btn_press` and `btn_release` for one channel are mutually exclusive in any cycle. Different channels may pulse in the same cycle.

## Timing
- All outputs are registered. Reset values: `btn_level`=0, `btn_press`=0, `btn_release`=0. The FSM resets to `IDLE`, counters to 0, sync flops to 1.
- Press latency: raw `btn_n` low sampled at edge k gives `btn_press` high during the cycle after edge k+2+DB_CYCLES, with `btn_level` rising in the same cycle. Release latency is identical.
- Pulse width is exactly 1 `vga_clk` cycle.
- Reset asserted mid-operation clears everything immediately. A button held through reset deassertion is re-debounced from `IDLE` and produces a fresh press after the full latency.

## Configuration
- `BTN_AUTOREPEAT_EN` defined: in `HELD`, when cnt reaches RPT_DELAY-1, pulse `btn_press` and set cnt←0. After that, pulse every RPT_PERIOD cycles while in `HELD`. Entering `REL_WAIT` then bouncing back to `HELD` restarts the delay from 0.
- `BTN_AUTOREPEAT_EN` undefined: no repeat logic. `RPT_*` parameters are ignored, and the counter only needs to cover DB_CYCLES.

## Structure
- Package `btn_pkg`: `btn_state_t` enum (`IDLE`, `PRESS_WAIT`, `HELD`, `REL_WAIT`), the default timing constants, and channel index constants `BTN_MOVE`=0 and `BTN_SELECT`=1.
- Sub-module `btn_channel`: synchroniser, counter and FSM for one button. `btn_conditioner` instantiates N_BTN of them in a generate loop.

## Test plan
All scenarios use DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3.
- **Clean press:** `btn_n[0]` low, held 20 cycles → `btn_press[0]` one pulse 7 cycles after the first sampling edge, `btn_level[0]`=1, channel 1 silent.
- **Bounce:** `btn_n[1]` toggles low 2 cycles, high 1 cycle, repeated 5×, then steady low → exactly one `btn_press[1]`, issued DB_CYCLES after the steady low is synchronised.
- **Release glitch:** while held, `btn_n[0]` high for 3 cycles then low → no `btn_release`, `btn_level` stays 1.
- **Release:** steady high after press → one `btn_release[0]` at the same latency as the press, then `btn_level`=0.
- **Reset:** `rst` low mid-`PRESS_WAIT` with button still low → all outputs 0 immediately. After `rst` high, the press pulse arrives a full 7 cycles later.
- **Auto-repeat** (macro defined): hold 30 cycles after the press → repeat pulses at +10, +13, +16, … cycles after the initial press. With the macro undefined, only the initial press pulse occurs.
